agc_gain_ctrl: RTL and testbench
================================

Name: agc_gain_ctrl

Overview:
Closed-loop gain controller for the AGC datapath. Consumes the windowed power measurement (one 37-bit power value per 64-sample window) and steps a 4-bit gain index up or down to keep power inside a target band. Adds settle blanking, lock detection and saturation flags. Sits between the power accumulator and the gain/shift stage.

Parameters:
PWR_HI, 80000, upper power threshold; unsigned, 37-bit compare.
PWR_LO, 48000, lower power threshold; PWR_LO < PWR_HI is required.
GAIN_INIT, 8, gain index loaded at reset and on restart.
GAIN_MIN, 0, lowest gain index.
GAIN_MAX, 15, highest gain index.
SETTLE_WIN, 2, windows discarded after each gain step; range 1..15.
LOCK_WIN, 4, consecutive in-band windows needed to lock; range 1..15.
LOSS_WIN, 3, consecutive out-of-band windows in TRACK before lock is lost; range 1..15.

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  loop enable level
restart  in  1  one-cycle pulse: reload GAIN_INIT and re-acquire
freeze  in  1  hold the gain; measurements are still evaluated for lock status
power_in  in  37  window power, unsigned
power_valid  in  1  one-cycle strobe; power_in is valid in that cycle
gain  out  4  current gain index to the shift stage
gain_change  out  1  one-cycle pulse in the cycle gain takes a new value
locked  out  1  loop locked
sat_hi  out  1  gain is GAIN_MAX and power is below PWR_LO
sat_lo  out  1  gain is GAIN_MIN and power is above PWR_HI
state  out  2  IDLE=0, ACQ=1, SETTLE=2, TRACK=3

Behaviour:
- Reset (asynchronous, may arrive mid-operation): state=IDLE, gain=GAIN_INIT, all counters=0, gain_change=0, locked=0, sat_hi=0, sat_lo=0.
- Window classification on power_valid:
  - HIGH: power_in > PWR_HI.
  - LOW: power_in < PWR_LO.
  - otherwise IN.
  - Values equal to a threshold count as IN.
- Step rule:
  - HIGH: gain-1, floored at GAIN_MIN.
  - LOW: gain+1, capped at GAIN_MAX.
  - gain_change asserts only if the value actually changes.
- Latency: gain, gain_change and the state transition are registered one cycle after the power_valid cycle.
- IDLE:
  - Gain held; power_valid ignored.
  - enable=1 -> ACQ next cycle.
- ACQ:
  - IN: in_cnt+1. When in_cnt reaches LOCK_WIN -> TRACK, locked=1.
  - HIGH/LOW with gain changed: in_cnt=0, settle_cnt=SETTLE_WIN -> SETTLE.
  - HIGH/LOW with gain saturated: in_cnt=0, stay in ACQ, set sat_hi or sat_lo.
- SETTLE:
  - Each power_valid decrements settle_cnt; the window is not classified.
  - When settle_cnt reaches 0 -> ACQ.
  - locked=0 throughout.
- TRACK:
  - IN: loss_cnt=0.
  - HIGH/LOW: loss_cnt+1.
  - When loss_cnt reaches LOSS_WIN: apply the step, locked=0, loss_cnt=0, then -> SETTLE if gain changed, else -> ACQ.
- sat_hi / sat_lo are updated on every classified window and cleared by any IN window or any gain change.
- freeze=1:
  - No gain step is applied; classification and counters still run.
  - A step-worthy window in ACQ clears in_cnt and keeps the state in ACQ.
  - In TRACK, loss at LOSS_WIN clears locked and goes to ACQ without a step.
- enable=0 in any state -> IDLE next cycle, locked=0, counters cleared, gain held. This has priority over a simultaneous power_valid.
- restart has priority over everything except reset:
  - gain=GAIN_INIT; gain_change=1 if the value differs.
  - Counters cleared, locked=0.
  - Next state: SETTLE with settle_cnt=SETTLE_WIN if enable=1, else IDLE.
- power_valid strobes closer together than 2 cycles need not be supported (windows are 64 cycles apart).

Decomposition:
- Shared package agc_pkg holds:
  - state encodings (IDLE/ACQ/SETTLE/TRACK);
  - class encodings (IN/HIGH/LOW);
  - widths: PWR_W=37, GAIN_W=4, CNT_W=4.
- One natural sub-module, agc_pwr_classify: registered-free comparator producing the HIGH/LOW/IN class from power_in, PWR_HI and PWR_LO.
- The FSM, counters and gain register stay in agc_gain_ctrl.

Test Plan:
- Reset then enable=1; feed 4 windows of power 60000 -> state ACQ then TRACK after the 4th strobe; locked=1; gain stays 8; gain_change never asserted.
- From ACQ, one window of power 100000 -> gain 7 with a gain_change pulse one cycle later, state SETTLE. The next 2 windows (any power) are ignored, then state ACQ.
- Drive power 1000 continuously from gain 8 -> gain climbs to 15 (settle gaps between steps). At 15, sat_hi=1 and gain does not wrap. Repeat with power 200000 down to gain 0: sat_lo=1.
- In TRACK: 2 HIGH windows then 1 IN -> still locked (loss_cnt cleared). Then 3 HIGH -> locked=0, gain-1, SETTLE.
- Boundary values: power exactly 80000 and exactly 48000 -> both classified IN, no step.
- Controls:
  - freeze=1 with power 1000 -> gain unchanged.
  - restart at gain 12 -> gain 8, gain_change pulse, SETTLE.
  - enable=0 coincident with power_valid -> IDLE, no step.
  - reset asserted mid-SETTLE -> outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain controller.
//   - loop state encodings (visible on the state output)
//   - window classification encodings
//   - datapath and counter widths
package agc_pkg;

    localparam int PWR_W  = 37;
    localparam int GAIN_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_TRACK  = 2'd3
    } agc_state_t;

    typedef enum logic [1:0] {
        CLS_IN   = 2'd0,
        CLS_HIGH = 2'd1,
        CLS_LOW  = 2'd2
    } pwr_class_t;

endpackage

// File: rtl/agc_pwr_classify.sv
// Window power classifier, purely combinational.
// Ports:
//   i_power  - window power, unsigned
//   o_class  - CLS_HIGH above PWR_HI, CLS_LOW below PWR_LO, else CLS_IN
// A power equal to either threshold counts as in-band.
module agc_pwr_classify
    import agc_pkg::*;
#(
    parameter logic [PWR_W-1:0] PWR_HI = 37'd80000,
    parameter logic [PWR_W-1:0] PWR_LO = 37'd48000
) (
    input  logic [PWR_W-1:0] i_power,
    output logic [1:0]       o_class
);

    always_comb begin
        o_class = CLS_IN;
        if (i_power > PWR_HI) begin
            o_class = CLS_HIGH;
        end else if (i_power < PWR_LO) begin
            o_class = CLS_LOW;
        end
    end

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain controller. Steps a gain index once per power window
// to keep the measured power between PWR_LO and PWR_HI, with settle blanking
// after each step, lock detection and saturation flags.
// Ports:
//   clk, reset (async, active-low)
//   enable, restart, freeze           - loop controls
//   power_in, power_valid             - one power value per window
//   gain, gain_change                 - gain index and its change pulse
//   locked, sat_hi, sat_lo, state     - loop status
//
// state  | meaning
// IDLE   | loop off, gain held, windows ignored
// ACQ    | counting consecutive in-band windows, stepping on out-of-band
// SETTLE | discarding windows after a gain step
// TRACK  | locked; counting consecutive out-of-band windows toward loss
module agc_gain_ctrl
    import agc_pkg::*;
#(
    parameter logic [PWR_W-1:0]  PWR_HI     = 37'd80000,
    parameter logic [PWR_W-1:0]  PWR_LO     = 37'd48000,
    parameter logic [GAIN_W-1:0] GAIN_INIT  = 4'd8,
    parameter logic [GAIN_W-1:0] GAIN_MIN   = 4'd0,
    parameter logic [GAIN_W-1:0] GAIN_MAX   = 4'd15,
    parameter logic [CNT_W-1:0]  SETTLE_WIN = 4'd2,
    parameter logic [CNT_W-1:0]  LOCK_WIN   = 4'd4,
    parameter logic [CNT_W-1:0]  LOSS_WIN   = 4'd3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic              freeze,
    input  logic [PWR_W-1:0]  power_in,
    input  logic              power_valid,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_change,
    output logic              locked,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic [1:0]        state
);

    agc_state_t        r_state;
    logic [GAIN_W-1:0] r_gain;
    logic              r_gain_change;
    logic              r_locked;
    logic              r_sat_hi;
    logic              r_sat_lo;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic [CNT_W-1:0]  r_loss_cnt;

    logic [1:0]        w_class;
    logic [GAIN_W-1:0] w_step_gain;
    logic              w_step_ok;
    logic              w_sat_hi;
    logic              w_sat_lo;

    agc_pwr_classify #(
        .PWR_HI (PWR_HI),
        .PWR_LO (PWR_LO)
    ) u_classify (
        .i_power (power_in),
        .o_class (w_class)
    );

    // Candidate gain for this window; equals r_gain when clamped at a limit.
    always_comb begin
        w_step_gain = r_gain;
        if (w_class == CLS_HIGH && r_gain != GAIN_MIN) begin
            w_step_gain = r_gain - 4'd1;
        end else if (w_class == CLS_LOW && r_gain != GAIN_MAX) begin
            w_step_gain = r_gain + 4'd1;
        end
    end

    assign w_step_ok = (w_step_gain != r_gain) && !freeze;
    // Evaluated against the pre-step gain, so a window that actually moves
    // the gain always yields zero here.
    assign w_sat_hi  = (w_class == CLS_LOW)  && (r_gain == GAIN_MAX);
    assign w_sat_lo  = (w_class == CLS_HIGH) && (r_gain == GAIN_MIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_gain        <= GAIN_INIT;
            r_gain_change <= 1'b0;
            r_locked      <= 1'b0;
            r_sat_hi      <= 1'b0;
            r_sat_lo      <= 1'b0;
            r_in_cnt      <= '0;
            r_settle_cnt  <= '0;
            r_loss_cnt    <= '0;
        end else begin
            r_gain_change <= 1'b0;
            if (restart) begin
                r_gain        <= GAIN_INIT;
                r_gain_change <= (r_gain != GAIN_INIT);
                r_locked      <= 1'b0;
                r_sat_hi      <= 1'b0;
                r_sat_lo      <= 1'b0;
                r_in_cnt      <= '0;
                r_loss_cnt    <= '0;
                if (enable) begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= SETTLE_WIN;
                end else begin
                    r_state      <= ST_IDLE;
                    r_settle_cnt <= '0;
                end
            end else if (!enable) begin
                r_state      <= ST_IDLE;
                r_locked     <= 1'b0;
                r_in_cnt     <= '0;
                r_settle_cnt <= '0;
                r_loss_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (power_valid) begin
                            r_sat_hi <= w_sat_hi;
                            r_sat_lo <= w_sat_lo;
                            if (w_class == CLS_IN) begin
                                if (r_in_cnt + 4'd1 == LOCK_WIN) begin
                                    r_state    <= ST_TRACK;
                                    r_locked   <= 1'b1;
                                    r_in_cnt   <= '0;
                                    r_loss_cnt <= '0;
                                end else begin
                                    r_in_cnt <= r_in_cnt + 4'd1;
                                end
                            end else begin
                                r_in_cnt <= '0;
                                if (w_step_ok) begin
                                    r_gain        <= w_step_gain;
                                    r_gain_change <= 1'b1;
                                    r_settle_cnt  <= SETTLE_WIN;
                                    r_state       <= ST_SETTLE;
                                end
                            end
                        end
                    end
                    ST_SETTLE: begin
                        r_locked <= 1'b0;
                        if (power_valid) begin
                            if (r_settle_cnt <= 4'd1) begin
                                r_settle_cnt <= '0;
                                r_state      <= ST_ACQ;
                            end else begin
                                r_settle_cnt <= r_settle_cnt - 4'd1;
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (power_valid) begin
                            r_sat_hi <= w_sat_hi;
                            r_sat_lo <= w_sat_lo;
                            if (w_class == CLS_IN) begin
                                r_loss_cnt <= '0;
                            end else if (r_loss_cnt + 4'd1 == LOSS_WIN) begin
                                r_loss_cnt <= '0;
                                r_locked   <= 1'b0;
                                if (w_step_ok) begin
                                    r_gain        <= w_step_gain;
                                    r_gain_change <= 1'b1;
                                    r_settle_cnt  <= SETTLE_WIN;
                                    r_state       <= ST_SETTLE;
                                end else begin
                                    r_state <= ST_ACQ;
                                end
                            end else begin
                                r_loss_cnt <= r_loss_cnt + 4'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign gain        = r_gain;
    assign gain_change = r_gain_change;
    assign locked      = r_locked;
    assign sat_hi      = r_sat_hi;
    assign sat_lo      = r_sat_lo;
    assign state       = r_state;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed bench for agc_gain_ctrl with hand-computed expectations.
module tb_agc_gain_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        restart;
    logic        freeze;
    logic [36:0] power_in;
    logic        power_valid;
    logic [3:0]  gain;
    logic        gain_change;
    logic        locked;
    logic        sat_hi;
    logic        sat_lo;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    agc_gain_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .restart     (restart),
        .freeze      (freeze),
        .power_in    (power_in),
        .power_valid (power_valid),
        .gain        (gain),
        .gain_change (gain_change),
        .locked      (locked),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge after the capturing edge.
    task automatic send(input logic [36:0] p);
        @(negedge clk);
        power_in    = p;
        power_valid = 1'b1;
        @(negedge clk);
        power_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int st, input int g, input int gc);
        check({tag, ".state"}, 64'(state), 64'(st));
        check({tag, ".gain"}, 64'(gain), 64'(g));
        check({tag, ".gchg"}, 64'(gain_change), 64'(gc));
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        restart     = 1'b0;
        freeze      = 1'b0;
        power_in    = '0;
        power_valid = 1'b0;

        #12;
        expect_out("rst", 0, 8, 0);
        check("rst.locked", 64'(locked), 64'd0);
        check("rst.sat_hi", 64'(sat_hi), 64'd0);
        check("rst.sat_lo", 64'(sat_lo), 64'd0);

        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("en.state", 64'(state), 64'd1);

        // Acquire lock with four in-band windows
        for (int i = 1; i <= 3; i++) begin
            send(37'd60000);
            expect_out("acq_in", 1, 8, 0);
        end
        send(37'd60000);
        expect_out("lock", 3, 8, 0);
        check("lock.locked", 64'(locked), 64'd1);

        // TRACK: two HIGH then IN keeps lock
        send(37'd100000);
        send(37'd100000);
        expect_out("trk_h2", 3, 8, 0);
        send(37'd60000);
        check("trk_in.locked", 64'(locked), 64'd1);
        send(37'd100000);
        send(37'd100000);
        check("trk_h2b.locked", 64'(locked), 64'd1);
        send(37'd100000);
        expect_out("loss", 2, 7, 1);
        check("loss.locked", 64'(locked), 64'd0);

        // Settle windows are not classified
        send(37'd5);
        expect_out("set1", 2, 7, 0);
        send(37'd5);
        expect_out("set2", 1, 7, 0);

        // Single HIGH window from ACQ
        send(37'd100000);
        expect_out("acq_hi", 2, 6, 1);
        @(negedge clk);
        check("acq_hi.pulse_end", 64'(gain_change), 64'd0);
        send(37'd100000);
        send(37'd100000);
        expect_out("acq_hi.settled", 1, 6, 0);

        // Threshold boundaries are in-band
        send(37'd80000);
        expect_out("bnd_hi", 1, 6, 0);
        send(37'd48000);
        expect_out("bnd_lo", 1, 6, 0);
        send(37'd47999);
        expect_out("bnd_lo_m1", 2, 7, 1);
        send(37'd1000);
        send(37'd1000);

        // Climb to GAIN_MAX
        for (int g = 8; g <= 15; g++) begin
            send(37'd1000);
            expect_out("climb", 2, g, 1);
            send(37'd1000);
            send(37'd1000);
            check("climb.acq", 64'(state), 64'd1);
        end
        send(37'd1000);
        expect_out("max", 1, 15, 0);
        check("max.sat_hi", 64'(sat_hi), 64'd1);
        send(37'd1000);
        check("max2.gain", 64'(gain), 64'd15);
        check("max2.sat_hi", 64'(sat_hi), 64'd1);
        send(37'd60000);
        check("max_in.sat_hi", 64'(sat_hi), 64'd0);

        // Descend to GAIN_MIN
        for (int g = 14; g >= 0; g--) begin
            send(37'd200000);
            expect_out("desc", 2, g, 1);
            send(37'd200000);
            send(37'd200000);
        end
        send(37'd200000);
        expect_out("min", 1, 0, 0);
        check("min.sat_lo", 64'(sat_lo), 64'd1);

        // Climb back to 12
        for (int g = 1; g <= 12; g++) begin
            send(37'd1000);
            check("reclimb.gain", 64'(gain), 64'(g));
            check("reclimb.sat_lo", 64'(sat_lo), 64'd0);
            send(37'd1000);
            send(37'd1000);
        end

        // Restart at gain 12
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        expect_out("restart", 2, 8, 1);
        check("restart.locked", 64'(locked), 64'd0);
        send(37'd60000);
        send(37'd60000);
        check("restart.acq", 64'(state), 64'd1);

        // Freeze blocks the step
        freeze = 1'b1;
        send(37'd1000);
        expect_out("freeze", 1, 8, 0);
        freeze = 1'b0;

        // enable=0 coincident with power_valid
        @(negedge clk);
        enable      = 1'b0;
        power_in    = 37'd1000;
        power_valid = 1'b1;
        @(negedge clk);
        power_valid = 1'b0;
        expect_out("dis", 0, 8, 0);
        send(37'd1000);
        expect_out("idle_ign", 0, 8, 0);

        // Async reset mid-SETTLE while gain_change is high
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        send(37'd100000);
        expect_out("pre_rst", 2, 7, 1);
        #1;
        reset = 1'b0;
        #1;
        expect_out("async_rst", 0, 8, 0);
        check("async_rst.locked", 64'(locked), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
